// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, hazard-unit stall/flush control,
// and saturating stall/flush event counters. All state moves on the falling edge.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 3,
  parameter int M_W    = 2,
  parameter int EX_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              valid,
  input  logic [WB_W-1:0]   WB,
  input  logic [M_W-1:0]    M,
  input  logic [EX_W-1:0]   EX,
  input  logic [DATA_W-1:0] read_Rs,
  input  logic [DATA_W-1:0] read_Rt,
  input  logic [DATA_W-1:0] sign_extended32,
  input  logic [DATA_W-1:0] pc4,
  input  logic [REG_W-1:0]  Rs,
  input  logic [REG_W-1:0]  Rt,
  input  logic [REG_W-1:0]  Rd,
  output logic              EX_valid,
  output logic [WB_W-1:0]   EX_WB,
  output logic [M_W-1:0]    EX_M,
  output logic [EX_W-1:0]   EX_EX,
  output logic [DATA_W-1:0] EX_read_Rs,
  output logic [DATA_W-1:0] EX_read_Rt,
  output logic [DATA_W-1:0] EX_sign_extended32,
  output logic [DATA_W-1:0] EX_pc4,
  output logic [REG_W-1:0]  EX_Rs,
  output logic [REG_W-1:0]  EX_Rt,
  output logic [REG_W-1:0]  EX_Rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_valid;
  logic [WB_W-1:0]   r_wb;
  logic [M_W-1:0]    r_m;
  logic [EX_W-1:0]   r_ex;
  logic [DATA_W-1:0] r_read_rs;
  logic [DATA_W-1:0] r_read_rt;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // Flush clears register numbers too, so a bubble can never match a forwarding compare.
  always_ff @(negedge clk) begin
    if (rst || flush) begin
      r_valid   <= 1'b0;
      r_wb      <= '0;
      r_m       <= '0;
      r_ex      <= '0;
      r_read_rs <= '0;
      r_read_rt <= '0;
      r_imm     <= '0;
      r_pc4     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else if (!stall) begin
      r_valid   <= valid;
      r_wb      <= WB;
      r_m       <= M;
      r_ex      <= EX;
      r_read_rs <= read_Rs;
      r_read_rt <= read_Rt;
      r_imm     <= sign_extended32;
      r_pc4     <= pc4;
      r_rs      <= Rs;
      r_rt      <= Rt;
      r_rd      <= Rd;
    end
  end

  // Only one counter can move per edge; flush masks stall.
  always_ff @(negedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush) begin
      if (r_flush_cnt != {CNT_W{1'b1}}) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (stall) begin
      if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign EX_valid           = r_valid;
  assign EX_WB              = r_wb;
  assign EX_M               = r_m;
  assign EX_EX              = r_ex;
  assign EX_read_Rs         = r_read_rs;
  assign EX_read_Rt         = r_read_rt;
  assign EX_sign_extended32 = r_imm;
  assign EX_pc4             = r_pc4;
  assign EX_Rs              = r_rs;
  assign EX_Rt              = r_rt;
  assign EX_Rd              = r_rd;
  assign stall_cnt          = r_stall_cnt;
  assign flush_cnt          = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load, hold, bubble, counters,
// plus a CNT_W=4 instance for saturation.
module tb_id_ex_pipe_reg;

  localparam int BUS_W = 1 + 3 + 2 + 3 + 4*32 + 3*5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, cnt_clr, valid;
  logic [2:0]  WB, EX;
  logic [1:0]  M;
  logic [31:0] read_Rs, read_Rt, imm, pc4;
  logic [4:0]  Rs, Rt, Rd;

  logic        o_valid;
  logic [2:0]  o_wb, o_ex;
  logic [1:0]  o_m;
  logic [31:0] o_rrs, o_rrt, o_imm, o_pc4;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [15:0] stall_cnt, flush_cnt;

  logic        stall_s, cnt_clr_s, flush_s;
  logic        s_valid;
  logic [2:0]  s_wb, s_ex;
  logic [1:0]  s_m;
  logic [31:0] s_rrs, s_rrt, s_imm, s_pc4;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .valid(valid), .WB(WB), .M(M), .EX(EX),
    .read_Rs(read_Rs), .read_Rt(read_Rt), .sign_extended32(imm), .pc4(pc4),
    .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .EX_valid(o_valid), .EX_WB(o_wb), .EX_M(o_m), .EX_EX(o_ex),
    .EX_read_Rs(o_rrs), .EX_read_Rt(o_rrt), .EX_sign_extended32(o_imm), .EX_pc4(o_pc4),
    .EX_Rs(o_rs), .EX_Rt(o_rt), .EX_Rd(o_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall_s), .flush(flush_s), .cnt_clr(cnt_clr_s),
    .valid(valid), .WB(WB), .M(M), .EX(EX),
    .read_Rs(read_Rs), .read_Rt(read_Rt), .sign_extended32(imm), .pc4(pc4),
    .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .EX_valid(s_valid), .EX_WB(s_wb), .EX_M(s_m), .EX_EX(s_ex),
    .EX_read_Rs(s_rrs), .EX_read_Rt(s_rrt), .EX_sign_extended32(s_imm), .EX_pc4(s_pc4),
    .EX_Rs(s_rs), .EX_Rt(s_rt), .EX_Rd(s_rd),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  logic [BUS_W-1:0] w_out_bus;
  assign w_out_bus = {o_valid, o_wb, o_m, o_ex, o_rrs, o_rrt, o_imm, o_pc4, o_rs, o_rt, o_rd};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1ns after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_a();
    valid = 1'b1; WB = 3'b110; M = 2'b01; EX = 3'b100;
    read_Rs = 32'h0000_0005; read_Rt = 32'hFFFF_FFFB;
    imm = 32'h0000_0010; pc4 = 32'h0000_0044;
    Rs = 5'd3; Rt = 5'd4; Rd = 5'd5;
  endtask

  task automatic drive_ones();
    valid = 1'b1; WB = '1; M = '1; EX = '1;
    read_Rs = '1; read_Rt = '1; imm = '1; pc4 = '1;
    Rs = '1; Rt = '1; Rd = '1;
  endtask

  logic [BUS_W-1:0] exp_a, exp_ones, exp_v0;

  initial begin
    exp_a    = {1'b1, 3'b110, 2'b01, 3'b100, 32'h0000_0005, 32'hFFFF_FFFB,
                32'h0000_0010, 32'h0000_0044, 5'd3, 5'd4, 5'd5};
    exp_ones = '1;
    exp_v0   = {1'b0, 3'b101, 2'b10, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0,
                32'hFFFF_FF80, 32'h0040_0008, 5'd31, 5'd0, 5'd17};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    stall_s = 1'b0; cnt_clr_s = 1'b0; flush_s = 1'b0;
    drive_a();
    #2;

    // Reset with random inputs, including stall/flush/cnt_clr
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom); flush = 1'($urandom); cnt_clr = 1'($urandom);
      valid = 1'($urandom); WB = 3'($urandom); M = 2'($urandom); EX = 3'($urandom);
      read_Rs = $urandom; read_Rt = $urandom; imm = $urandom; pc4 = $urandom;
      Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom);
      tick();
    end
    chk("reset_bus", w_out_bus, '0);
    chk("reset_stall_cnt", BUS_W'(stall_cnt), '0);
    chk("reset_flush_cnt", BUS_W'(flush_cnt), '0);

    rst = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drive_a();
    tick();
    chk("load_a", w_out_bus, exp_a);
    chk("load_valid", BUS_W'(o_valid), BUS_W'(1));

    stall = 1'b1;
    drive_ones();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), w_out_bus, exp_a);
    end
    chk("stall_cnt_3", BUS_W'(stall_cnt), BUS_W'(3));
    chk("flush_cnt_0", BUS_W'(flush_cnt), '0);

    stall = 1'b0;
    tick();
    chk("release_ones", w_out_bus, exp_ones);
    chk("stall_cnt_after_release", BUS_W'(stall_cnt), BUS_W'(3));

    drive_a();
    tick();
    chk("reload_a", w_out_bus, exp_a);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("stall_flush_bubble", w_out_bus, '0);
    chk("stall_flush_fcnt", BUS_W'(flush_cnt), BUS_W'(1));
    chk("stall_flush_scnt", BUS_W'(stall_cnt), BUS_W'(3));

    // valid=0 load: controls are not masked
    stall = 1'b0; flush = 1'b0;
    valid = 1'b0; WB = 3'b101; M = 2'b10; EX = 3'b011;
    read_Rs = 32'h1234_5678; read_Rt = 32'h9ABC_DEF0; imm = 32'hFFFF_FF80; pc4 = 32'h0040_0008;
    Rs = 5'd31; Rt = 5'd0; Rd = 5'd17;
    tick();
    chk("valid0_load", w_out_bus, exp_v0);

    flush = 1'b1;
    tick();
    chk("flush_only_bubble", w_out_bus, '0);
    chk("flush_only_fcnt", BUS_W'(flush_cnt), BUS_W'(2));

    // cnt_clr beats a concurrent flush increment
    cnt_clr = 1'b1;
    tick();
    chk("clr_fcnt", BUS_W'(flush_cnt), '0);
    chk("clr_scnt", BUS_W'(stall_cnt), '0);

    cnt_clr = 1'b0; flush = 1'b0;
    drive_a();
    tick();
    stall = 1'b1;
    drive_ones();
    tick();
    tick();
    chk("pre_rst_scnt", BUS_W'(stall_cnt), BUS_W'(2));
    chk("pre_rst_hold", w_out_bus, exp_a);
    rst = 1'b1;
    tick();
    chk("mid_stall_rst_bus", w_out_bus, '0);
    chk("mid_stall_rst_scnt", BUS_W'(stall_cnt), '0);
    rst = 1'b0;
    tick();
    chk("post_rst_hold_zero", w_out_bus, '0);
    chk("post_rst_scnt", BUS_W'(stall_cnt), BUS_W'(1));
    stall = 1'b0;

    // Saturation on the 4-bit counter instance
    chk("small_start", BUS_W'(s_stall_cnt), '0);
    stall_s = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("small_edge14", BUS_W'(s_stall_cnt), BUS_W'(14));
      if (i == 15) chk("small_edge15", BUS_W'(s_stall_cnt), BUS_W'(15));
    end
    chk("small_sat20", BUS_W'(s_stall_cnt), BUS_W'(15));
    cnt_clr_s = 1'b1;
    tick();
    chk("small_clr", BUS_W'(s_stall_cnt), '0);
    chk("small_fcnt", BUS_W'(s_flush_cnt), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
